hdmi_frame_measure: RTL and testbench
=====================================

Name: hdmi_frame_measure

Overview:
Sits directly downstream of the DVI receiver wrapper in the rgb_clk domain, alongside the pixel-batching input stage. Watches DE/HS/VS, measures the active width and height of each frame, and qualifies the format as stable before asserting image_valid. Supplies per-pixel x/y coordinates and a frame-start pulse to the batching logic. Reports the stable resolution to the output logic.

Parameters:
MAX_WIDTH, 1920, largest accepted active width in pixels
MAX_HEIGHT, 1080, largest accepted active height in lines
STABLE_FRAMES, 2, consecutive identical good frames required before lock (>=1)
VS_ACTIVE_HIGH, 1, 1: frame boundary on VS rising edge; 0: on VS falling edge
TIMEOUT_CYCLES, 4000000, VS watchdog limit in rgb_clk cycles (used only with the optional feature)

Ports:
I_rgb_clk  input  1  pixel clock from the DVI receiver
I_rst_n  input  1  reset, asynchronous, active-low
I_rgb_de  input  1  data enable
I_rgb_hs  input  1  horizontal sync, for monitoring only, never used for measurement
I_rgb_vs  input  1  vertical sync
O_x  output  $clog2(MAX_WIDTH+1)  index of current DE pixel within the line
O_y  output  $clog2(MAX_HEIGHT+1)  index of current active line within the frame
O_frame_start  output  1  one-cycle pulse per frame boundary
O_image_width  output  $clog2(MAX_WIDTH+1)  locked active width
O_image_height  output  $clog2(MAX_HEIGHT+1)  locked active height
O_image_valid  output  1  high while the format is locked
O_frame_error  output  1  one-cycle pulse when a frame fails checks

Behaviour:
- Clocking and reset: single clock, I_rgb_clk. Reset is asynchronous and active-low on I_rst_n.
- Reset values: every output is 0. State is SEARCH. All counters, the candidate width/height, and the stable count are cleared.
- Sync registration: VS and DE are registered once. A frame edge is detected at cycle t when the registered VS makes the active transition. O_frame_start pulses at t+1 in every state.
- Pixel counter: increments on each cycle with DE high. It saturates at MAX_WIDTH+1, which marks overflow.
- Line closure: a DE falling edge closes the line.
  - The first line of the frame sets the frame reference width.
  - Any later line whose length differs from the reference sets frame_bad.
  - The line counter increments on each closure and saturates at MAX_HEIGHT+1.
- O_x / O_y: these are the live counter values and are meaningful only while DE is high. O_y resets at each frame edge.
- Overflow or empty frame: frame_bad is also set when width > MAX_WIDTH, height > MAX_HEIGHT, or a frame closes with height 0.
- DE still high at the frame edge: frame_bad is set.
- Simultaneous line close and frame edge: the line is closed first, and the frame is then evaluated using the updated counts.
- States:
  - SEARCH: wait for a frame edge, then go to MEASURE. Counts from a partial frame are discarded.
  - MEASURE, at each frame edge:
    - If frame_bad: pulse O_frame_error at t+1 and set stable_cnt to 0.
    - Else if (w,h) equals the candidate: stable_cnt increments, saturating.
    - Else: the candidate becomes (w,h) and stable_cnt becomes 1.
    - When stable_cnt reaches STABLE_FRAMES, go to LOCKED. At t+1, O_image_width/O_image_height take the candidate and O_image_valid rises.
  - LOCKED, at each frame edge:
    - A good frame matching the candidate keeps the lock.
    - A bad or differing frame clears O_image_valid at t+1 and goes to MEASURE. The candidate is reloaded with the new (w,h) and stable_cnt is set to 1, or to 0 if the frame was bad.
- Held outputs: O_image_width/O_image_height hold their last locked values while valid is low. Consumers qualify them with O_image_valid.
- Reset mid-frame: outputs clear immediately. The block needs one full frame edge-to-edge before measuring again.

Optional Feature:
- Macro: HDMI_FRAME_MEASURE_TIMEOUT_EN.
- When defined: a watchdog counts cycles since the last frame edge in MEASURE and LOCKED. On reaching TIMEOUT_CYCLES:
  - O_image_valid clears on the next cycle.
  - O_frame_error pulses.
  - State goes to SEARCH.
  - stable_cnt is set to 0.
- When not defined: there is no watchdog counter. A lost VS leaves O_image_valid at its last value.

Decomposition:
- Shared package video_pkg holds:
  - the state enum (SEARCH, MEASURE, LOCKED);
  - the width helpers WIDTH_BITS(MAX) = $clog2(MAX+1);
  - the default MAX_WIDTH/MAX_HEIGHT constants, which the top-level and output logic also use.
- One sub-module, sync_edge_detect: it registers a level and emits rise/fall pulses. It is instantiated for VS and DE.

Test Plan:
1. Reset, then 4 frames of 128x32 (STABLE_FRAMES=2) -> O_image_valid rises 1 cycle after the 3rd frame edge; width=128, height=32; O_frame_start pulses at every edge.
2. Locked at 128x32, switch to 64x16 -> valid falls 1 cycle after the first 64x16 frame edge; it rises again after the next 64x16 frame with width=64, height=16.
3. One line of 127 pixels inside a 128x32 frame -> O_frame_error pulses at that frame's edge; valid falls; relock takes 2 good frames.
4. Defaults, a line with 1921 DE cycles -> frame_bad and O_frame_error; valid stays 0; O_x saturates at 1921.
5. I_rst_n low mid-frame while locked -> all outputs 0 in the same cycle; after release, no lock before the 3rd frame edge.
6. With HDMI_FRAME_MEASURE_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stop VS while locked -> valid falls 1 cycle after the count reaches 1000; O_frame_error pulses once; state is SEARCH.

Source files
------------

// File: rtl/hdmi_frame_measure_pkg.sv
// Shared video definitions: frame-lock states, counter width helper and default raster limits.
package video_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } frame_state_e;

  localparam int DEF_MAX_WIDTH  = 1920;
  localparam int DEF_MAX_HEIGHT = 1080;

  // Bits needed to hold 0..max inclusive (max+1 is the overflow marker).
  function automatic int WIDTH_BITS(input int max_v);
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/hdmi_frame_measure_if.sv
// Raw DVI sync bundle plus the measured-format results.
interface hdmi_frame_measure_if #(
  parameter int XW = video_pkg::WIDTH_BITS(video_pkg::DEF_MAX_WIDTH),
  parameter int YW = video_pkg::WIDTH_BITS(video_pkg::DEF_MAX_HEIGHT)
);
  logic          de;
  logic          hs;
  logic          vs;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;
  logic [XW-1:0] image_width;
  logic [YW-1:0] image_height;
  logic          image_valid;
  logic          frame_error;

  modport master (
    output de, hs, vs,
    input  x, y, frame_start, image_width, image_height, image_valid, frame_error
  );

  modport slave (
    input  de, hs, vs,
    output x, y, frame_start, image_width, image_height, image_valid, frame_error
  );
endinterface

// File: rtl/hdmi_frame_measure_sync_edge_detect.sv
// Registers one level and flags its rising/falling transitions on the registered copy.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic level_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic level_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_i;
      prev_q  <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;
  assign fall_o  = ~level_q & prev_q;
endmodule

// File: rtl/hdmi_frame_measure.sv
// Measures active width/height per frame from DE/VS and locks onto a stable format.
// Optional VS watchdog enabled by defining HDMI_FRAME_MEASURE_TIMEOUT_EN.
module hdmi_frame_measure
  import video_pkg::*;
#(
  parameter int MAX_WIDTH      = DEF_MAX_WIDTH,
  parameter int MAX_HEIGHT     = DEF_MAX_HEIGHT,
  parameter int STABLE_FRAMES  = 2,
  parameter int VS_ACTIVE_HIGH = 1,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                            I_rgb_clk,
  input  logic                            I_rst_n,
  input  logic                            I_rgb_de,
  input  logic                            I_rgb_hs,
  input  logic                            I_rgb_vs,
  output logic [$clog2(MAX_WIDTH+1)-1:0]  O_x,
  output logic [$clog2(MAX_HEIGHT+1)-1:0] O_y,
  output logic                            O_frame_start,
  output logic [$clog2(MAX_WIDTH+1)-1:0]  O_image_width,
  output logic [$clog2(MAX_HEIGHT+1)-1:0] O_image_height,
  output logic                            O_image_valid,
  output logic                            O_frame_error
);
  localparam int XW = WIDTH_BITS(MAX_WIDTH);
  localparam int YW = WIDTH_BITS(MAX_HEIGHT);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [XW-1:0] X_MAX = XW'(MAX_WIDTH);
  localparam logic [XW-1:0] X_SAT = XW'(MAX_WIDTH + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAX_HEIGHT);
  localparam logic [YW-1:0] Y_SAT = YW'(MAX_HEIGHT + 1);
  localparam logic [SW-1:0] SF    = SW'(STABLE_FRAMES);

  // HS is carried for monitoring only; measurement never depends on it.
  logic unused_hs;
  assign unused_hs = I_rgb_hs;

  logic vs_rise, vs_fall, vs_lvl_unused;
  logic de_q, de_fall, de_rise_unused;

  sync_edge_detect u_vs_edge (
    .clk_i(I_rgb_clk), .rst_n_i(I_rst_n), .level_i(I_rgb_vs),
    .level_o(vs_lvl_unused), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  sync_edge_detect u_de_edge (
    .clk_i(I_rgb_clk), .rst_n_i(I_rst_n), .level_i(I_rgb_de),
    .level_o(de_q), .rise_o(de_rise_unused), .fall_o(de_fall)
  );

  logic frm_edge;
  assign frm_edge = (VS_ACTIVE_HIGH != 0) ? vs_rise : vs_fall;

  logic [XW-1:0] px_cnt_q, ref_w_q, cand_w_q, img_w_q;
  logic [YW-1:0] line_cnt_q, cand_h_q, img_h_q;
  logic [SW-1:0] stable_q;
  logic          bad_q, fs_q, err_q, valid_q;
  frame_state_e  state_q;

  logic          first_line, bad_line, bad_eff, match;
  logic [XW-1:0] w_eff;
  logic [YW-1:0] h_eff;
  logic [SW-1:0] stable_inc;

  // A line closing on the frame-edge cycle is folded in before the frame is judged.
  always_comb begin
    first_line = (line_cnt_q == '0);
    h_eff      = line_cnt_q;
    w_eff      = ref_w_q;
    bad_line   = 1'b0;
    if (de_fall) begin
      if (line_cnt_q != Y_SAT) h_eff = line_cnt_q + YW'(1);
      if (first_line) w_eff = px_cnt_q;
      else bad_line = (px_cnt_q != ref_w_q);
    end
    bad_eff    = bad_q | bad_line | (frm_edge & de_q) | (w_eff > X_MAX) |
                 (h_eff == '0) | (h_eff > Y_MAX);
    match      = (w_eff == cand_w_q) && (h_eff == cand_h_q);
    stable_inc = (stable_q >= SF) ? stable_q : stable_q + SW'(1);
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      px_cnt_q   <= '0;
      line_cnt_q <= '0;
      ref_w_q    <= '0;
      bad_q      <= 1'b0;
    end else if (frm_edge) begin
      px_cnt_q   <= '0;
      line_cnt_q <= '0;
      bad_q      <= 1'b0;
    end else if (de_fall) begin
      px_cnt_q   <= '0;
      line_cnt_q <= h_eff;
      bad_q      <= bad_q | bad_line;
      if (first_line) ref_w_q <= px_cnt_q;
    end else if (de_q && (px_cnt_q != X_SAT)) begin
      px_cnt_q   <= px_cnt_q + XW'(1);
    end
  end

  logic wd_hit;
`ifdef HDMI_FRAME_MEASURE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt_q;

  assign wd_hit = (state_q != SEARCH) && !frm_edge && (wd_cnt_q == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n)                             wd_cnt_q <= '0;
    else if (frm_edge || state_q == SEARCH)   wd_cnt_q <= '0;
    else if (wd_cnt_q != WW'(TIMEOUT_CYCLES)) wd_cnt_q <= wd_cnt_q + WW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= SEARCH;
      cand_w_q <= '0;
      cand_h_q <= '0;
      stable_q <= '0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      img_w_q  <= '0;
      img_h_q  <= '0;
    end else begin
      fs_q  <= frm_edge;
      err_q <= 1'b0;
      if (wd_hit) begin
        state_q  <= SEARCH;
        valid_q  <= 1'b0;
        err_q    <= 1'b1;
        stable_q <= '0;
      end else if (frm_edge) begin
        case (state_q)
          SEARCH: state_q <= MEASURE;
          MEASURE: begin
            if (bad_eff) begin
              err_q    <= 1'b1;
              stable_q <= '0;
            end else begin
              cand_w_q <= w_eff;
              cand_h_q <= h_eff;
              stable_q <= match ? stable_inc : SW'(1);
              if ((match ? stable_inc : SW'(1)) >= SF) begin
                state_q <= LOCKED;
                valid_q <= 1'b1;
                img_w_q <= w_eff;
                img_h_q <= h_eff;
              end
            end
          end
          LOCKED: begin
            if (bad_eff || !match) begin
              state_q  <= MEASURE;
              valid_q  <= 1'b0;
              err_q    <= bad_eff;
              cand_w_q <= w_eff;
              cand_h_q <= h_eff;
              stable_q <= bad_eff ? SW'(0) : SW'(1);
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign O_x            = px_cnt_q;
  assign O_y            = line_cnt_q;
  assign O_frame_start  = fs_q;
  assign O_frame_error  = err_q;
  assign O_image_valid  = valid_q;
  assign O_image_width  = img_w_q;
  assign O_image_height = img_h_q;
endmodule

// File: tb/tb_hdmi_frame_measure.sv
// Directed bench: lock, format change, bad line, mid-frame reset and width overflow.
module tb_hdmi_frame_measure;
  import video_pkg::*;

  localparam int XW = WIDTH_BITS(DEF_MAX_WIDTH);
  localparam int YW = WIDTH_BITS(DEF_MAX_HEIGHT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdmi_frame_measure_if #(.XW(XW), .YW(YW)) vif ();

  hdmi_frame_measure dut (
    .I_rgb_clk      (clk),
    .I_rst_n        (rst_n),
    .I_rgb_de       (vif.de),
    .I_rgb_hs       (vif.hs),
    .I_rgb_vs       (vif.vs),
    .O_x            (vif.x),
    .O_y            (vif.y),
    .O_frame_start  (vif.frame_start),
    .O_image_width  (vif.image_width),
    .O_image_height (vif.image_height),
    .O_image_valid  (vif.image_valid),
    .O_frame_error  (vif.frame_error)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] val_pre, fs_seen, err_seen, val_seen, w_seen, h_seen;
  logic [31:0] fs_after, err_after, x_mid, y_mid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(vif.image_valid), 0);
    check({tag, "_w"},     32'(vif.image_width), 0);
    check({tag, "_h"},     32'(vif.image_height), 0);
    check({tag, "_x"},     32'(vif.x), 0);
    check({tag, "_y"},     32'(vif.y), 0);
    check({tag, "_fs"},    32'(vif.frame_start), 0);
    check({tag, "_err"},   32'(vif.frame_error), 0);
  endtask

  task automatic step(input logic de, input logic vs);
    vif.de = de;
    vif.vs = vs;
    @(posedge clk);
    #1;
  endtask

  // Edge cycle follows the first VS step; registered outputs appear after the second.
  task automatic vs_pulse();
    step(1'b0, 1'b1);
    val_pre  = 32'(vif.image_valid);
    step(1'b0, 1'b1);
    fs_seen  = 32'(vif.frame_start);
    err_seen = 32'(vif.frame_error);
    val_seen = 32'(vif.image_valid);
    w_seen   = 32'(vif.image_width);
    h_seen   = 32'(vif.image_height);
    step(1'b0, 1'b1);
    fs_after  = 32'(vif.frame_start);
    err_after = 32'(vif.frame_error);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
  endtask

  task automatic send_lines(input int w, input int h, input int bad_idx, input int bad_w);
    for (int l = 0; l < h; l++) begin
      int len;
      len = (l == bad_idx) ? bad_w : w;
      for (int p = 0; p < len; p++) begin
        step(1'b1, 1'b0);
        if (l == 3 && p == 9) begin
          x_mid = 32'(vif.x);
          y_mid = 32'(vif.y);
        end
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic frame(input int w, input int h, input int bad_idx, input int bad_w);
    vs_pulse();
    send_lines(w, h, bad_idx, bad_w);
  endtask

  initial begin
    vif.de = 1'b0;
    vif.hs = 1'b0;
    vif.vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Four 128x32 frames: lock on the third edge.
    frame(128, 32, -1, 0);
    check("t1_e1_fs", fs_seen, 1);
    check("t1_e1_fs_after", fs_after, 0);
    check("t1_e1_valid", val_seen, 0);
    check("t1_x_mid", x_mid, 9);
    check("t1_y_mid", y_mid, 3);
    frame(128, 32, -1, 0);
    check("t1_e2_valid", val_seen, 0);
    check("t1_e2_err", err_seen, 0);
    check("t1_e2_fs", fs_seen, 1);
    frame(128, 32, -1, 0);
    check("t1_e3_valid_pre", val_pre, 0);
    check("t1_e3_valid", val_seen, 1);
    check("t1_e3_w", w_seen, 128);
    check("t1_e3_h", h_seen, 32);
    check("t1_e3_fs", fs_seen, 1);
    frame(128, 32, -1, 0);
    check("t1_e4_valid", val_seen, 1);

    // Format change to 64x16.
    frame(64, 16, -1, 0);
    check("t2_a_valid", val_seen, 1);
    check("t2_a_w", w_seen, 128);
    check("t2_x_mid", x_mid, 9);
    check("t2_y_mid", y_mid, 3);
    frame(64, 16, -1, 0);
    check("t2_b_valid_pre", val_pre, 1);
    check("t2_b_valid", val_seen, 0);
    check("t2_b_err", err_seen, 0);
    check("t2_b_w_held", w_seen, 128);
    check("t2_b_h_held", h_seen, 32);
    frame(64, 16, -1, 0);
    check("t2_c_valid", val_seen, 1);
    check("t2_c_w", w_seen, 64);
    check("t2_c_h", h_seen, 16);

    // Back to 128x32, then a frame with one short line.
    frame(128, 32, -1, 0);
    check("t3_g1_valid", val_seen, 1);
    check("t3_g1_w", w_seen, 64);
    frame(128, 32, -1, 0);
    check("t3_g2_valid", val_seen, 0);
    frame(128, 32, 5, 127);
    check("t3_b_valid", val_seen, 1);
    check("t3_b_w", w_seen, 128);
    check("t3_b_h", h_seen, 32);
    frame(128, 32, -1, 0);
    check("t3_g3_valid_pre", val_pre, 1);
    check("t3_g3_err", err_seen, 1);
    check("t3_g3_err_after", err_after, 0);
    check("t3_g3_valid", val_seen, 0);
    frame(128, 32, -1, 0);
    check("t3_g4_valid", val_seen, 0);
    check("t3_g4_err", err_seen, 0);

    // Relock, then reset in the middle of a line.
    vs_pulse();
    check("t5_relock_valid", val_seen, 1);
    check("t5_relock_w", w_seen, 128);
    send_lines(128, 3, -1, 0);
    repeat (50) step(1'b1, 1'b0);
    check("t5_pre_x", 32'(vif.x), 49);
    check("t5_pre_y", 32'(vif.y), 3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    vif.de = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(128, 32, -1, 0);
    check("t5_e1_valid", val_seen, 0);
    check("t5_e1_fs", fs_seen, 1);
    frame(128, 32, -1, 0);
    check("t5_e2_valid", val_seen, 0);
    vs_pulse();
    check("t5_e3_valid", val_seen, 1);
    check("t5_e3_w", w_seen, 128);
    check("t5_e3_h", h_seen, 32);

    // Width overflow from a fresh reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    vs_pulse();
    check("t4_e1_err", err_seen, 0);
    check("t4_e1_valid", val_seen, 0);
    for (int p = 0; p < 1925; p++) begin
      step(1'b1, 1'b0);
      if (p == 999) check("t4_x_1000", 32'(vif.x), 999);
    end
    check("t4_x_sat", 32'(vif.x), 1921);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    vs_pulse();
    check("t4_e2_fs", fs_seen, 1);
    check("t4_e2_err", err_seen, 1);
    check("t4_e2_err_after", err_after, 0);
    check("t4_e2_valid", val_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
